// File: rtl/forwarding_ctrl.sv
// Operand-forwarding select and load-use stall control for the 5-stage RV32I pipeline.
// Tracks destination info of the instructions ahead of ID and registers the execute-stage selects.
module forwarding_ctrl #(
    parameter bit         LOAD_USE_STALL = 1'b1,
    parameter logic [6:0] I_TYPE_LOAD    = 7'b0000011
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       flush,
    output logic [1:0] forward_select_A,
    output logic [1:0] forward_select_B,
    output logic       stall_IF_ID,
    output logic       bubble_EX
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } dst_t;

    typedef struct packed {
        dst_t dst;
        logic is_load;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;

    // The WB-stage copy is not kept: nothing here reads it, and a WB-to-ID
    // collision is covered by register-file write-through.
    slot_t  ex_q, ex_d;
    dst_t   mem_q, mem_d;
    state_t state_q, state_d;
    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_b_q, sel_b_d;

    logic hazard;
    logic stall;
    logic bubble;

    function automatic logic writes_reg(input dst_t d, input logic [4:0] r);
        return d.valid && d.regwrite && (d.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] pick_sel(input logic squash, input logic uses,
                                            input logic [4:0] r,
                                            input dst_t ex_dst, input dst_t mem_dst);
        if (squash || !uses)          return SEL_NONE;
        else if (writes_reg(ex_dst, r))  return SEL_MEM;
        else if (writes_reg(mem_dst, r)) return SEL_WB;
        else                          return SEL_NONE;
    endfunction

    always_comb begin
        hazard = LOAD_USE_STALL && id_valid && ex_q.is_load &&
                 ((id_uses_rs1 && writes_reg(ex_q.dst, id_rs1)) ||
                  (id_uses_rs2 && writes_reg(ex_q.dst, id_rs2)));
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                stall = hazard && !flush;
                if (stall) state_d = STALL;
            end
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign bubble = stall || flush;

    always_comb begin
        ex_d = '0;
        if (!bubble && id_valid) begin
            ex_d.dst.valid    = 1'b1;
            ex_d.dst.rd       = id_rd;
            ex_d.dst.regwrite = id_regwrite;
            ex_d.is_load      = (id_opcode == I_TYPE_LOAD);
        end
        mem_d   = ex_q.dst;
        sel_a_d = pick_sel(bubble || !id_valid, id_uses_rs1, id_rs1, ex_q.dst, mem_q);
        sel_b_d = pick_sel(bubble || !id_valid, id_uses_rs2, id_rs2, ex_q.dst, mem_q);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            sel_a_q <= SEL_NONE;
            sel_b_q <= SEL_NONE;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign forward_select_A = sel_a_q;
    assign forward_select_B = sel_b_q;
    assign stall_IF_ID      = stall;
    assign bubble_EX        = bubble;

endmodule

// File: tb/tb_forwarding_ctrl.sv
// Self-checking bench for forwarding_ctrl: directed vector table, hand sequences for
// reset/parameter corners, and random stimulus against an instruction-history model.
module tb_forwarding_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_uses_rs1, id_uses_rs2, flush;
    logic [1:0] fa1, fb1, fa0, fb0;
    logic       stall1, bubble1, stall0, bubble0;

    always #5 clock = ~clock;

    forwarding_ctrl #(.LOAD_USE_STALL(1'b1), .I_TYPE_LOAD(OP_LD)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .flush(flush),
        .forward_select_A(fa1), .forward_select_B(fb1),
        .stall_IF_ID(stall1), .bubble_EX(bubble1)
    );

    forwarding_ctrl #(.LOAD_USE_STALL(1'b0), .I_TYPE_LOAD(OP_LD)) dut0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .flush(flush),
        .forward_select_A(fa0), .forward_select_B(fb0),
        .stall_IF_ID(stall0), .bubble_EX(bubble0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       rw, u1, u2, fl;
        logic       e_stall, e_bubble;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [6:0] op,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic u1, input logic u2, input logic fl,
                                input logic es, input logic eb, input logic [1:0] ea, input logic [1:0] ebb);
        vec_t t;
        t.v = v; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.rw = rw; t.u1 = u1; t.u2 = u2; t.fl = fl;
        t.e_stall = es; t.e_bubble = eb; t.e_fa = ea; t.e_fb = ebb;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v; id_opcode = t.op; id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
        id_regwrite = t.rw; id_uses_rs1 = t.u1; id_uses_rs2 = t.u2; flush = t.fl;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset_fa", {30'd0, fa1}, 0);
        check("reset_fb", {30'd0, fb1}, 0);
        check("reset_stall", {31'd0, stall1}, 0);
        check("reset_bubble", {31'd0, bubble1}, 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference model: a history of what entered EX; the newest entry is the
    // producer one stage ahead of a consumer, the one before it two stages ahead.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } mop_t;

    mop_t h1[$];
    mop_t h0[$];
    bit   st1, st0;

    function automatic bit wr(input mop_t o, input logic [4:0] r);
        return o.v && o.rw && (o.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] msel(input bit squash, input logic uses, input logic [4:0] r,
                                        input mop_t newest, input mop_t older);
        if (squash || !uses) return 2'd0;
        if (wr(newest, r))   return 2'd2;
        if (wr(older, r))    return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step(input bit lus, input mop_t newest, input mop_t older, input bit in_st,
                              output bit stall, output bit bubble,
                              output logic [1:0] fa, output logic [1:0] fb, output mop_t issued);
        bit hz;
        hz = lus && id_valid && newest.ld &&
             ((id_uses_rs1 && wr(newest, id_rs1)) || (id_uses_rs2 && wr(newest, id_rs2)));
        stall  = !in_st && hz && !flush;
        bubble = stall || flush;
        issued = (bubble || !id_valid) ? '0 : {1'b1, id_rd, id_regwrite, id_opcode == OP_LD};
        fa = msel(bubble || !id_valid, id_uses_rs1, id_rs1, newest, older);
        fb = msel(bubble || !id_valid, id_uses_rs2, id_rs2, newest, older);
    endtask

    vec_t tbl[19];
    vec_t idle;

    initial begin
        mop_t n1, o1, n0, o0, is1, is0;
        bit ms1, mb1, ms0, mb0;
        logic [1:0] mfa1, mfb1, mfa0, mfb0;

        idle = mk(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drive(idle);

        tbl[0]  = mk(1, OP_R,   1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0); // add x5,x1,x2
        tbl[1]  = mk(1, OP_R,   5, 3, 6, 1, 1, 1, 0, 0, 0, 2, 0); // sub x6,x5,x3
        tbl[2]  = idle;
        tbl[3]  = mk(1, OP_R,   1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0); // add x5,x1,x2
        tbl[4]  = idle;                                           // nop
        tbl[5]  = mk(1, OP_R,   4, 5, 7, 1, 1, 1, 0, 0, 0, 0, 1); // or x7,x4,x5
        tbl[6]  = mk(1, OP_LD,  1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0); // lw x8,0(x1)
        tbl[7]  = mk(1, OP_R,   8, 8, 9, 1, 1, 1, 0, 1, 1, 0, 0); // add x9,x8,x8 stalls
        tbl[8]  = mk(1, OP_R,   8, 8, 9, 1, 1, 1, 0, 0, 0, 1, 1); // add held, WB data
        tbl[9]  = mk(1, OP_I,   1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0); // addi x0,x1,1
        tbl[10] = mk(1, OP_R,   0, 0, 3, 1, 1, 1, 0, 0, 0, 0, 0); // add x3,x0,x0
        tbl[11] = mk(1, OP_R,   1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0); // add x5,x1,x2
        tbl[12] = mk(1, OP_LUI, 5, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0); // lui x5
        tbl[13] = mk(1, OP_LD,  1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0); // lw x8,0(x1)
        tbl[14] = mk(1, OP_R,   8, 8, 9, 1, 1, 1, 1, 0, 1, 0, 0); // add + flush
        tbl[15] = idle;
        tbl[16] = mk(1, OP_R,   1, 2, 5, 1, 1, 1, 0, 0, 0, 0, 0); // add x5,x1,x2
        tbl[17] = mk(1, OP_R,   1, 1, 5, 1, 1, 1, 0, 0, 0, 0, 0); // add x5,x1,x1
        tbl[18] = mk(1, OP_R,   5, 5, 6, 1, 1, 1, 0, 0, 0, 2, 2); // sub x6,x5,x5

        do_reset();

        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            check($sformatf("tbl%0d_stall", i), {31'd0, stall1}, {31'd0, tbl[i].e_stall});
            check($sformatf("tbl%0d_bubble", i), {31'd0, bubble1}, {31'd0, tbl[i].e_bubble});
            @(posedge clock);
            #1;
            check($sformatf("tbl%0d_fa", i), {30'd0, fa1}, {30'd0, tbl[i].e_fa});
            check($sformatf("tbl%0d_fb", i), {30'd0, fb1}, {30'd0, tbl[i].e_fb});
        end

        // Asynchronous reset while the selects hold 10/10.
        #1 reset = 1'b1;
        #1;
        check("async_rst_fa", {30'd0, fa1}, 0);
        check("async_rst_fb", {30'd0, fb1}, 0);
        @(negedge clock);
        reset = 1'b0;

        // Reset pulsed during the stall cycle.
        drive(mk(1, OP_LD, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        drive(mk(1, OP_R, 8, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0));
        #1;
        check("pre_stall", {31'd0, stall1}, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midstall_rst_stall", {31'd0, stall1}, 0);
        check("midstall_rst_bubble", {31'd0, bubble1}, 0);
        check("midstall_rst_fa", {30'd0, fa1}, 0);
        check("midstall_rst_fb", {30'd0, fb1}, 0);
        @(negedge clock);
        reset = 1'b0;
        drive(idle);

        // Load then consumer: both instances side by side.
        @(negedge clock);
        drive(mk(1, OP_LD, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        drive(mk(1, OP_R, 8, 8, 9, 1, 1, 1, 0, 0, 0, 0, 0));
        #1;
        check("lus1_stall", {31'd0, stall1}, 1);
        check("lus1_bubble", {31'd0, bubble1}, 1);
        check("lus0_stall", {31'd0, stall0}, 0);
        check("lus0_bubble", {31'd0, bubble0}, 0);
        @(posedge clock);
        #1;
        check("lus0_fa", {30'd0, fa0}, 2);
        check("lus0_fb", {30'd0, fb0}, 2);
        @(negedge clock);
        #1;
        check("lus1_release", {31'd0, stall1}, 0);
        @(posedge clock);
        #1;
        check("lus1_fa", {30'd0, fa1}, 1);
        check("lus1_fb", {30'd0, fb1}, 1);
        @(negedge clock);
        drive(idle);

        // Random phase against the history model.
        do_reset();
        h1.delete(); h0.delete();
        st1 = 0; st0 = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (!st1) begin
                id_valid    = ($urandom_range(7) != 0);
                id_opcode   = ($urandom_range(2) == 0) ? OP_LD : OP_R;
                id_rs1      = 5'($urandom_range(3));
                id_rs2      = 5'($urandom_range(3));
                id_rd       = 5'($urandom_range(3));
                id_regwrite = ($urandom_range(3) != 0);
                id_uses_rs1 = ($urandom_range(3) != 0);
                id_uses_rs2 = ($urandom_range(1) != 0);
            end
            flush = ($urandom_range(7) == 0);
            #1;
            n1 = (h1.size() > 0) ? h1[h1.size()-1] : '0;
            o1 = (h1.size() > 1) ? h1[h1.size()-2] : '0;
            n0 = (h0.size() > 0) ? h0[h0.size()-1] : '0;
            o0 = (h0.size() > 1) ? h0[h0.size()-2] : '0;
            model_step(1'b1, n1, o1, st1, ms1, mb1, mfa1, mfb1, is1);
            model_step(1'b0, n0, o0, st0, ms0, mb0, mfa0, mfb0, is0);
            check("rnd_stall1", {31'd0, stall1}, {31'd0, ms1});
            check("rnd_bubble1", {31'd0, bubble1}, {31'd0, mb1});
            check("rnd_stall0", {31'd0, stall0}, {31'd0, ms0});
            check("rnd_bubble0", {31'd0, bubble0}, {31'd0, mb0});
            @(posedge clock);
            #1;
            check("rnd_fa1", {30'd0, fa1}, {30'd0, mfa1});
            check("rnd_fb1", {30'd0, fb1}, {30'd0, mfb1});
            check("rnd_fa0", {30'd0, fa0}, {30'd0, mfa0});
            check("rnd_fb0", {30'd0, fb0}, {30'd0, mfb0});
            h1.push_back(is1);
            h0.push_back(is0);
            if (h1.size() > 4) void'(h1.pop_front());
            if (h0.size() > 4) void'(h0.pop_front());
            st1 = ms1;
            st0 = ms0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
